gate_truth_table_checker: RTL and testbench

GATE_TRUTH_TABLE_CHECKER -- requirements
Module: gate_truth_table_checker

---
 rtl/gate_truth_table_checker_pkg.sv | 28 ++
 rtl/gate_truth_table_checker_if.sv | 35 +++
 rtl/gate_truth_table_checker_expected.sv | 23 ++
 rtl/gate_truth_table_checker.sv | 134 +++++++++++++
 tb/tb_gate_truth_table_checker.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/gate_truth_table_checker_pkg.sv
// gate_chk_pkg
//   Shared definitions for the gate truth-table checker: FSM state encoding,
//   bit positions of each gate result inside gate_in, and sizing constants.
package gate_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // gate_in / expected vector bit order
    localparam int GATE_W    = 6;
    localparam int GATE_AND  = 5;
    localparam int GATE_OR   = 4;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 2;
    localparam int GATE_XOR  = 1;
    localparam int GATE_XNOR = 0;

    localparam int NUM_VECTORS = 4;
    localparam int IDX_W       = 2;
    localparam int CNT_W       = 4;
    localparam int ERR_W       = 3;

endpackage

// File: rtl/gate_truth_table_checker_if.sv
// gate_truth_table_checker_if
//   Bundles the checker's control/status handshake and the operand/result
//   bus to the gate block under test.
//   start          : sweep request (checker input)
//   a_out, b_out   : operands driven to the gate block
//   gate_in        : gate results returned by the gate block
//   busy, done     : sweep in progress / one-cycle end-of-sweep pulse
//   pass           : sweep result
//   fail_mask      : per-vector mismatch flags
//   err_count      : number of mismatching vectors
//   master modport : the checker; slave modport : whoever drives it.
interface gate_truth_table_checker_if;
    import gate_chk_pkg::*;

    logic                   start;
    logic                   a_out;
    logic                   b_out;
    logic [GATE_W-1:0]      gate_in;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [NUM_VECTORS-1:0] fail_mask;
    logic [ERR_W-1:0]       err_count;

    modport master (
        input  start, gate_in,
        output a_out, b_out, busy, done, pass, fail_mask, err_count
    );

    modport slave (
        output start, gate_in,
        input  a_out, b_out, busy, done, pass, fail_mask, err_count
    );

endinterface

// File: rtl/gate_truth_table_checker_expected.sv
// gate_expected
//   Combinational reference for the six two-input gates.
//   a, b     : operands
//   expected : reference results in gate_in bit order
module gate_expected
    import gate_chk_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [GATE_W-1:0] expected
);

    always_comb begin
        expected            = '0;
        expected[GATE_AND]  = a & b;
        expected[GATE_OR]   = a | b;
        expected[GATE_NAND] = ~(a & b);
        expected[GATE_NOR]  = ~(a | b);
        expected[GATE_XOR]  = a ^ b;
        expected[GATE_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker
//   Sweeps the four operand combinations (00, 01, 10, 11) through an
//   external gate block, waits SETTLE_CYCLES (0..15) after each drive,
//   and compares the returned results against gate_expected.
//   Ports: clk, rst (async, active high), bus (master modport of
//   gate_truth_table_checker_if: start in, a_out/b_out out, gate_in in,
//   busy/done/pass/fail_mask/err_count out).
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | operands 0, waiting for start; results held
//   DRIVE  | launch operands for vector idx (1 cycle)
//   SETTLE | wait SETTLE_CYCLES with operands stable (down-counter)
//   SAMPLE | compare gate_in with expected, record mismatch (1 cycle)
//   DONE   | publish pass, schedule done pulse, return to IDLE (1 cycle)
//
//   done and pass are registered on the edge that leaves DONE, so the
//   done pulse coincides with the first IDLE cycle.
module gate_truth_table_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
)
(
    input  logic                        clk,
    input  logic                        rst,
    gate_truth_table_checker_if.master  bus
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       settle_cnt;
    logic                   a_q;
    logic                   b_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic [NUM_VECTORS-1:0] fail_mask_q;
    logic [ERR_W-1:0]       err_count_q;
    logic [GATE_W-1:0]      expected;
    logic                   mismatch;

    gate_expected u_expected (
        .a        (a_q),
        .b        (b_q),
        .expected (expected)
    );

    assign mismatch = (bus.gate_in != expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            settle_cnt  <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
            err_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    a_q <= 1'b0;
                    b_q <= 1'b0;
                    if (bus.start) begin
                        state       <= ST_DRIVE;
                        busy_q      <= 1'b1;
                        idx         <= '0;
                        fail_mask_q <= '0;
                        err_count_q <= '0;
                        pass_q      <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    a_q <= idx[1];
                    b_q <= idx[0];
                    if (SETTLE_CYCLES == 0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        fail_mask_q[idx] <= 1'b1;
                        err_count_q      <= err_count_q + ERR_W'(1);
                    end
                    if (idx == IDX_W'(NUM_VECTORS - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    // err_count already includes the final compare here
                    done_q <= 1'b1;
                    pass_q <= (err_count_q == '0);
                    busy_q <= 1'b0;
                    a_q    <= 1'b0;
                    b_q    <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb_gate_truth_table_checker
//   Drives two checkers (SETTLE_CYCLES=2 and 0) sharing start/rst, each
//   connected to a behavioural gate block; the SETTLE_CYCLES=2 block can
//   have result bits forced low/high to emulate a broken gate.
module tb_gate_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] stuck0;
    logic [5:0] stuck1;
    logic       sel0;
    int         n_cmp = 0;
    int         n_err = 0;

    // Hand-written truth table, bit order and,or,nand,nor,xor,xnor
    function automatic logic [5:0] gate_model(input logic a, input logic b);
        case ({a, b})
            2'b00:        return 6'b001101;
            2'b01, 2'b10: return 6'b011010;
            default:      return 6'b110001;
        endcase
    endfunction

    gate_truth_table_checker_if bus2 ();
    gate_truth_table_checker_if bus0 ();

    assign bus2.start   = start;
    assign bus0.start   = start;
    assign bus2.gate_in = (gate_model(bus2.a_out, bus2.b_out) & ~stuck0) | stuck1;
    assign bus0.gate_in = gate_model(bus0.a_out, bus0.b_out);

    gate_truth_table_checker #(.SETTLE_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    gate_truth_table_checker #(.SETTLE_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;

    wire       obs_a    = sel0 ? bus0.a_out     : bus2.a_out;
    wire       obs_b    = sel0 ? bus0.b_out     : bus2.b_out;
    wire       obs_busy = sel0 ? bus0.busy      : bus2.busy;
    wire       obs_done = sel0 ? bus0.done      : bus2.done;
    wire       obs_pass = sel0 ? bus0.pass      : bus2.pass;
    wire [3:0] obs_mask = sel0 ? bus0.fail_mask : bus2.fail_mask;
    wire [2:0] obs_err  = sel0 ? bus0.err_count : bus2.err_count;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] mask,
                                 input logic [2:0] err, input logic pass, input logic busy);
        chk({tag, "_mask"}, {4'b0, obs_mask}, {4'b0, mask});
        chk({tag, "_err"},  {5'b0, obs_err},  {5'b0, err});
        chk({tag, "_pass"}, {7'b0, obs_pass}, {7'b0, pass});
        chk({tag, "_busy"}, {7'b0, obs_busy}, {7'b0, busy});
    endtask

    // One pulsed-start sweep; n counts edges after the accepting edge k,
    // sampled on the following falling edge.
    task automatic sweep(input string tag, input logic use0, input int step, input int exp_lat,
                         input logic [3:0] exp_mask, input logic [2:0] exp_err, input logic exp_pass);
        logic [1:0] exp_ab [4];
        int done_at;
        int done_cnt;
        int vec;
        exp_ab   = '{2'b00, 2'b01, 2'b10, 2'b11};
        done_at  = -1;
        done_cnt = 0;
        vec      = 0;
        sel0     = use0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n <= 30; n++) begin
            if (n == 1) chk({tag, "_busy_run"}, {7'b0, obs_busy}, 8'd1);
            if (vec < 4 && n == 1 + vec * step) begin
                chk({tag, "_ab"}, {6'b0, obs_a, obs_b}, {6'b0, exp_ab[vec]});
                vec++;
            end
            if (obs_done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = n;
                    chk({tag, "_pass_at_done"}, {7'b0, obs_pass}, {7'b0, exp_pass});
                end
            end
            @(negedge clk);
        end
        chk({tag, "_latency"}, 8'(done_at), 8'(exp_lat));
        chk({tag, "_done_cnt"}, 8'(done_cnt), 8'd1);
        check_outputs({tag, "_final"}, exp_mask, exp_err, exp_pass, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, dcnt, idle_cnt;
        rst    = 1'b1;
        start  = 1'b0;
        stuck0 = '0;
        stuck1 = '0;
        sel0   = 1'b0;
        #1;
        check_outputs("reset", 4'b0000, 3'd0, 1'b0, 1'b0);
        chk("reset_done", {7'b0, obs_done}, 8'd0);
        chk("reset_ab", {6'b0, obs_a, obs_b}, 8'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        sweep("clean", 1'b0, 4, 17, 4'b0000, 3'd0, 1'b1);

        stuck0 = 6'b000010;
        sweep("xor_sa0", 1'b0, 4, 17, 4'b0110, 3'd2, 1'b0);
        stuck0 = '0;

        stuck1 = 6'b001000;
        sweep("nand_sa1", 1'b0, 4, 17, 4'b1000, 3'd1, 1'b0);
        stuck1 = '0;

        // Reset during SETTLE of vector 2 (xor fault so results are nonzero)
        sel0   = 1'b0;
        stuck0 = 6'b000010;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_a", {7'b0, obs_a}, 8'd1);
        check_outputs("pre_rst", 4'b0010, 3'd1, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_outputs("in_rst", 4'b0000, 3'd0, 1'b0, 1'b0);
        chk("in_rst_ab", {6'b0, obs_a, obs_b}, 8'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        stuck0 = '0;
        dcnt   = 0;
        for (int n = 0; n < 30; n++) begin
            if (bus2.done) dcnt++;
            @(negedge clk);
        end
        chk("post_rst_no_done", 8'(dcnt), 8'd0);
        sweep("after_rst", 1'b0, 4, 17, 4'b0000, 3'd0, 1'b1);

        // start held high: back-to-back sweeps with one IDLE cycle between
        sel0     = 1'b0;
        d1       = -1;
        d2       = -1;
        dcnt     = 0;
        idle_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            if (bus2.done) begin
                dcnt++;
                if (d1 < 0) d1 = n;
                else if (d2 < 0) d2 = n;
            end
            if (n <= 34 && !bus2.busy) idle_cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("held_done1", 8'(d1), 8'd17);
        chk("held_done2", 8'(d2), 8'd35);
        chk("held_done_cnt", 8'(dcnt), 8'd2);
        chk("held_idle_cycles", 8'(idle_cnt), 8'd1);
        repeat (40) @(negedge clk);
        check_outputs("held_final", 4'b0000, 3'd0, 1'b1, 1'b0);

        sweep("settle0", 1'b1, 2, 9, 4'b0000, 3'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
